// File: rtl/booth_shreg_pkg.sv
// rtl/booth_shreg_pkg.sv - shared constants, controller state type and counter-width helper
package booth_shreg_pkg;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

   function automatic int cnt_w(input int steps);
      return $clog2(steps + 1);
   endfunction

endpackage

// File: rtl/booth_shreg_ctrl.sv
// rtl/booth_shreg_ctrl.sv - step counter and busy/done sequencing for the Booth shift register
module booth_shreg_ctrl
   import booth_shreg_pkg::*;
#(
   parameter int STEPS = 4,
   parameter int CW    = cnt_w(STEPS)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ld,
   input  logic          shift,
   output logic          step_en,
   output logic [CW-1:0] cnt,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

   ctrl_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      step_en = 1'b0;
      if (clr) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (ld) begin
         state_d = ST_RUN;
         cnt_d   = '0;
      end else if (shift && (state_q == ST_RUN)) begin
         step_en = 1'b1;
         cnt_d   = cnt_q + CW'(1);
         if (cnt_q == LAST_CNT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign busy = (state_q == ST_RUN);
   assign done = done_q;

endmodule

// File: rtl/booth_shift_reg.sv
// rtl/booth_shift_reg.sv - parametrised Booth multiplier/product shift register
// Optional sign-fill on right steps with BOOTH_SHREG_ARITH_EN.
module booth_shift_reg
   import booth_shreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 2,
   parameter int STEPS = WIDTH / STEP
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       ld,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       shift,
   input  logic                       dir,
   input  logic [STEP-1:0]            shift_in,
`ifdef BOOTH_SHREG_ARITH_EN
   input  logic                       arith,
`endif
   output logic [WIDTH-1:0]           data_out,
   output logic [STEP-1:0]            shift_out,
   output logic [cnt_w(STEPS)-1:0]    cnt,
   output logic                       busy,
   output logic                       done
);

   localparam int CW = cnt_w(STEPS);

   if ((WIDTH % STEP) != 0) begin : g_chk_mult
      $error("booth_shift_reg: WIDTH must be a multiple of STEP");
   end
   if ((STEP < 1) || (STEP >= WIDTH)) begin : g_chk_step
      $error("booth_shift_reg: STEP must satisfy 1 <= STEP < WIDTH");
   end
   if (STEPS < 1) begin : g_chk_steps
      $error("booth_shift_reg: STEPS must be at least 1");
   end

   logic             step_en;
   logic [WIDTH-1:0] data_q, data_d;
   logic [STEP-1:0]  sout_q, sout_d;
   logic [STEP-1:0]  right_fill;

   booth_shreg_ctrl #(
      .STEPS (STEPS),
      .CW    (CW)
   ) u_ctrl (
      .clk     (clk),
      .clr     (clr),
      .ld      (ld),
      .shift   (shift),
      .step_en (step_en),
      .cnt     (cnt),
      .busy    (busy),
      .done    (done)
   );

`ifdef BOOTH_SHREG_ARITH_EN
   assign right_fill = arith ? {STEP{data_q[WIDTH-1]}} : shift_in;
`else
   assign right_fill = shift_in;
`endif

   // The controller only grants a step when no load or clear is pending.
   always_comb begin
      data_d = data_q;
      sout_d = sout_q;
      if (ld) begin
         data_d = data_in;
         sout_d = '0;
      end else if (step_en) begin
         if (dir == DIR_LEFT) begin
            data_d = {data_q[WIDTH-STEP-1:0], shift_in};
            sout_d = data_q[WIDTH-1:WIDTH-STEP];
         end else begin
            data_d = {right_fill, data_q[WIDTH-1:STEP]};
            sout_d = data_q[STEP-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         data_q <= '0;
         sout_q <= '0;
      end else begin
         data_q <= data_d;
         sout_q <= sout_d;
      end
   end

   assign data_out  = data_q;
   assign shift_out = sout_q;

endmodule

// File: tb/tb_booth_shift_reg.sv
// tb/tb_booth_shift_reg.sv - directed self-checking bench for booth_shift_reg (WIDTH=8, STEP=2)
module tb_booth_shift_reg;

   logic       clk = 1'b0;
   logic       clr, ld, shift, dir;
   logic [7:0] data_in;
   logic [1:0] shift_in;
   logic       arith;
   logic [7:0] data_out;
   logic [1:0] shift_out;
   logic [2:0] cnt;
   logic       busy, done;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   booth_shift_reg #(.WIDTH(8), .STEP(2)) dut (
      .clk       (clk),
      .clr       (clr),
      .ld        (ld),
      .data_in   (data_in),
      .shift     (shift),
      .dir       (dir),
      .shift_in  (shift_in),
`ifdef BOOTH_SHREG_ARITH_EN
      .arith     (arith),
`endif
      .data_out  (data_out),
      .shift_out (shift_out),
      .cnt       (cnt),
      .busy      (busy),
      .done      (done)
   );

   task automatic tick(input logic c, input logic l, input logic s, input logic d,
                       input logic [7:0] din, input logic [1:0] sin);
      clr = c; ld = l; shift = s; dir = d; data_in = din; shift_in = sin;
      @(posedge clk);
      #1;
      clr = 1'b0; ld = 1'b0; shift = 1'b0;
   endtask

   task automatic test_reset();
      arith = 1'b1;
      tick(1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 2'b11);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 2'b10);
      arith = 1'b0;
      vectors++;
      if ({data_out, shift_out, cnt, busy, done} !== {8'h00, 2'b00, 3'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: got data=%h so=%b cnt=%0d busy=%b done=%b, want 00/00/0/0/0",
                  data_out, shift_out, cnt, busy, done);
      end
   endtask

   task automatic test_right_steps();
      logic [7:0] exp_d [4] = '{8'h6D, 8'h5B, 8'h56, 8'h55};
      logic [1:0] exp_s [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'hB4, 2'b00);
      vectors++;
      if ({data_out, cnt, busy, done} !== {8'hB4, 3'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL load_b4: got data=%h cnt=%0d busy=%b done=%b, want b4/0/1/0",
                  data_out, cnt, busy, done);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
         vectors++;
         if ({data_out, shift_out, cnt} !== {exp_d[i], exp_s[i], 3'(i + 1)}) begin
            miscompares++;
            $display("FAIL right_step%0d: got data=%h so=%b cnt=%0d, want %h/%b/%0d",
                     i, data_out, shift_out, cnt, exp_d[i], exp_s[i], i + 1);
         end
         vectors++;
         if ({busy, done} !== ((i == 3) ? 2'b01 : 2'b10)) begin
            miscompares++;
            $display("FAIL right_flags%0d: got busy=%b done=%b", i, busy, done);
         end
      end
      // Extra shift after completion must be ignored and done must drop.
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
      vectors++;
      if ({data_out, shift_out, cnt, busy, done} !== {8'h55, 2'b10, 3'd4, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL idle_shift: got data=%h so=%b cnt=%0d busy=%b done=%b, want 55/10/4/0/0",
                  data_out, shift_out, cnt, busy, done);
      end
   endtask

   task automatic test_left_step();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h81, 2'b00);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2'b11);
      vectors++;
      if ({data_out, shift_out, cnt} !== {8'h07, 2'b10, 3'd1}) begin
         miscompares++;
         $display("FAIL left_step: got data=%h so=%b cnt=%0d, want 07/10/1",
                  data_out, shift_out, cnt);
      end
      // Stall then a right step: 0x07 -> {00, 000001} = 0x01, so = 11.
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
      vectors++;
      if ({data_out, shift_out, cnt, busy} !== {8'h01, 2'b11, 3'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL mixed_dir: got data=%h so=%b cnt=%0d busy=%b, want 01/11/2/1",
                  data_out, shift_out, cnt, busy);
      end
   endtask

`ifdef BOOTH_SHREG_ARITH_EN
   task automatic test_arith();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 2'b00);
      arith = 1'b1;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
      arith = 1'b0;
      vectors++;
      if ({data_out, shift_out} !== {8'hE0, 2'b00}) begin
         miscompares++;
         $display("FAIL arith_right: got data=%h so=%b, want e0/00", data_out, shift_out);
      end
   endtask
`endif

   task automatic test_ld_and_shift();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 2'b11);
      vectors++;
      if ({data_out, shift_out, cnt, busy} !== {8'h3C, 2'b00, 3'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL ld_wins: got data=%h so=%b cnt=%0d busy=%b, want 3c/00/0/1",
                  data_out, shift_out, cnt, busy);
      end
   endtask

   task automatic test_clr_mid_op();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 2'b00);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
      vectors++;
      if ({data_out, shift_out, cnt, busy, done} !== {8'h00, 2'b00, 3'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL clr_mid: got data=%h so=%b cnt=%0d busy=%b done=%b, want 00/00/0/0/0",
                  data_out, shift_out, cnt, busy, done);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
      vectors++;
      if ({data_out, cnt, busy, done} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL clr_after: got data=%h cnt=%0d busy=%b done=%b, want 00/0/0/0",
                  data_out, cnt, busy, done);
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 2'b00);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2'b00);
      vectors++;
      if ({data_out, cnt, done} !== {8'h00, 3'd4, 1'b1}) begin
         miscompares++;
         $display("FAIL final_step: got data=%h cnt=%0d done=%b, want 00/4/1", data_out, cnt, done);
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h96, 2'b00);
      vectors++;
      if ({data_out, shift_out, cnt, busy, done} !== {8'h96, 2'b00, 3'd0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL restart: got data=%h so=%b cnt=%0d busy=%b done=%b, want 96/00/0/1/0",
                  data_out, shift_out, cnt, busy, done);
      end
   endtask

   initial begin
      clr = 1'b0; ld = 1'b0; shift = 1'b0; dir = 1'b0;
      data_in = '0; shift_in = '0; arith = 1'b0;
      test_reset();
      test_right_steps();
      test_left_step();
`ifdef BOOTH_SHREG_ARITH_EN
      test_arith();
`endif
      test_ld_and_shift();
      test_clr_mid_op();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/booth_shift_reg.md
# booth_shift_reg

Parametrised multiplier/product shift register for the radix-4 Booth datapath, generalised to any width and bits-per-step. It supports left and right shifts, exposes the shifted-out bits, and counts steps so the Booth controller gets a registered `done` pulse when an operation has finished. It sits beside the accumulator and replaces the fixed 8-bit, 2-bit-step register in multiplier datapaths of any size.

## Interface
- `WIDTH`, 8: register width in bits; must be a multiple of `STEP`.
- `STEP`, 2: bits shifted per step (2 for radix-4); 1 ≤ `STEP` < `WIDTH`.
- `STEPS`, `WIDTH/STEP`: shifts per operation before `done`; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `ld`  in  1  load `data_in` and start an operation.
- `data_in`  in  `WIDTH`  parallel load value.
- `shift`  in  1  perform one step this cycle (honoured only while `busy`).
- `dir`  in  1  0 = right (toward LSB), 1 = left.
- `shift_in`  in  `STEP`  bits entering the vacated end.
- `arith`  in  1  sign-fill on right shift (present only with `BOOTH_SHREG_ARITH_EN`).
- `data_out`  out  `WIDTH`  register contents.
- `shift_out`  out  `STEP`  bits shifted out on the most recent step.
- `cnt`  out  `$clog2(STEPS+1)`  steps taken in the current operation.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse after the final step.

## Operation
- Priority each cycle: `clr` > `ld` > `shift`.
- `clr`: `data_out`, `shift_out`, `cnt`, `busy` and `done` all go to 0.
- `ld`: `data_out`←`data_in`, `cnt`←0, `busy`←1, `done`←0, `shift_out`←0.
  - Asserting `ld` while `busy` aborts the current operation and restarts.
  - If `shift` is also high, the shift is ignored.
- Right step: `data_out`←{`shift_in`, `data_out[WIDTH-1:STEP]`}; `shift_out`←`data_out[STEP-1:0]`.
- Left step: `data_out`←{`data_out[WIDTH-STEP-1:0]`, `shift_in`}; `shift_out`←`data_out[WIDTH-1:WIDTH-STEP]`.
- Every accepted step increments `cnt`.
- The step taken when `cnt` == `STEPS-1` sets `cnt`←`STEPS`, `busy`←0 and `done`←1.
- `shift` while `busy` = 0 is ignored. `data_out`, `shift_out` and `cnt` hold their values.
- Controller states:
  - IDLE (`busy`=0): `ld` moves to RUN.
  - RUN (`busy`=1): the final step returns to IDLE and pulses `done`.
  - `clr` in either state moves to IDLE.
- `done` is high for exactly one cycle and clears on the next edge unless `ld`/`clr` already cleared it.
- `dir` and `shift_in` are sampled per step. Mixing directions within one operation is legal.

## Timing
- All outputs are registered. A step is visible on `data_out`/`shift_out` one cycle after `shift` is sampled.
- `done` is asserted in the same cycle that `data_out` shows the final step's result.
- Minimum operation: 1 load cycle + `STEPS` consecutive shift cycles. `shift` may stall; steps are not lost.
- `clr` mid-operation takes effect at the next edge. No step is completed and no `done` is raised.

## Configuration
- `BOOTH_SHREG_ARITH_EN` defined:
  - Adds the `arith` port.
  - Right step with `arith`=1 fills the top `STEP` bits with `data_out[WIDTH-1]` and ignores `shift_in`.
  - Left steps are unaffected.
- Undefined: no `arith` port. Fill always comes from `shift_in`.

## Structure
- Package `booth_shreg_pkg`: `DIR_RIGHT`=0 and `DIR_LEFT`=1 constants, plus a counter-width function `cnt_w(steps)` = `$clog2(steps+1)`.
- Sub-module `booth_shreg_ctrl` holds `cnt`, `busy` and `done`. It outputs a step-enable to the datapath, which the top level owns.
- Parameter checks (`WIDTH % STEP` == 0, `STEP` < `WIDTH`) run as elaboration-time assertions.

## Test plan
All cases use `WIDTH`=8, `STEP`=2.
- Reset: assert `clr` with garbage on the inputs → `data_out`=0x00, `cnt`=0, `busy`=0, `done`=0.
- Load 0xB4, then right steps with `shift_in`=2'b01:
  - First step → `data_out`=0x6D, `shift_out`=2'b00.
  - After the fourth step → `cnt`=4, `busy`=0, one-cycle `done`.
- A fifth `shift` after `done` → `data_out`, `shift_out` and `cnt` unchanged; `done` stays 0.
- Load 0x81, left step with `shift_in`=2'b11 → `data_out`=0x07, `shift_out`=2'b10.
- `BOOTH_SHREG_ARITH_EN`: load 0x80, right step with `arith`=1 and `shift_in`=2'b00 → `data_out`=0xE0.
- Boundary cases:
  - `ld` and `shift` together → load wins with `cnt`=0.
  - `clr` after two steps → all outputs 0 and no `done`.
  - `ld` in the cycle after the final step → restart with `done` cleared.
